// File: rtl/inst_issue_pkg.sv
// Shared types and opcode helpers for the instruction issue queue.
package inst_issue_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  localparam logic [7:0] NOP_INST = 8'h00;

  // Instruction word layout: {op, rd, rs1, rs2}
  typedef struct packed {
    logic [1:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
  } inst_t;

  // One in-flight register write tracked by the scoreboard
  typedef struct packed {
    logic       wr;
    logic [1:0] rd;
  } sb_ent_t;

  // ADD and NAND are the only opcodes that read source registers
  function automatic logic reads_rs(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_NAND);
  endfunction

  // Everything but NOP writes rd
  function automatic logic writes_rd(input logic [1:0] op);
    return op != OP_NOP;
  endfunction

endpackage

// File: rtl/inst_issue_queue_if.sv
// Source-side handshake plus issue bus of the instruction issue queue.
interface inst_issue_queue_if;
  logic       in_valid;
  logic [7:0] in_inst;
  logic       in_ready;
  logic [7:0] inst;
  logic       issued;

  modport master (output in_valid, in_inst, input in_ready, inst, issued);
  modport slave  (input in_valid, in_inst, output in_ready, inst, issued);
endinterface

// File: rtl/inst_fifo.sv
// DEPTH x W circular FIFO with occupancy count; head is read combinationally.
module inst_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  // Full blocks pushes even when a pop happens in the same cycle
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rp];

  // Storage carries no reset; validity is tracked by level alone
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/inst_issue_queue.sv
// Instruction issue queue: buffers fetched instructions and issues one per
// cycle, inserting NOP bubbles on an empty queue or a RAW hazard.
// Optional feature macro: INST_ISSUE_FWD_EN (pipeline forwards results, so
// only the instruction issued last cycle can cause a stall).
module inst_issue_queue
  import inst_issue_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int HAZ_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  inst_issue_queue_if.slave      bus,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       bubble_cnt
);

`ifdef INST_ISSUE_FWD_EN
  // With forwarding a result is usable one cycle after issue; with a single
  // cycle of write latency nothing ever needs to wait.
  localparam int CHK_N = (HAZ_DEPTH > 1) ? 1 : 0;
`else
  localparam int CHK_N = HAZ_DEPTH;
`endif

  logic                    full, empty, push, pop, hazard, stall;
  logic [7:0]              fifo_rdata;
  inst_t                   head;
  sb_ent_t [HAZ_DEPTH-1:0] sb;
  sb_ent_t                 sb_new;
  logic [7:0]              inst_q;
  logic                    issued_q;

  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;
  assign head         = inst_t'(fifo_rdata);

  inst_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.in_inst),
    .rdata (fifo_rdata),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // RAW check of the head's sources against the in-flight writes that are
  // not yet visible (entry 0 = issued last cycle)
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++)
      if (i < CHK_N && sb[i].wr && reads_rs(head.op) &&
          (sb[i].rd == head.rs1 || sb[i].rd == head.rs2))
        hazard = 1'b1;
  end

  // Empty-queue NOPs are not stalls; only a blocked head is
  assign pop    = !empty && !hazard;
  assign stall  = !empty && hazard;
  assign sb_new = '{wr: pop && writes_rd(head.op), rd: head.rd};

  // Issue register: head on pop, NOP otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_q   <= NOP_INST;
      issued_q <= 1'b0;
    end else begin
      inst_q   <= pop ? fifo_rdata : NOP_INST;
      issued_q <= pop;
    end
  end

  assign bus.inst   = inst_q;
  assign bus.issued = issued_q;

  // Scoreboard shifts every cycle; bubbles and NOPs enter as empty slots
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb <= '0;
    end else begin
      for (int i = HAZ_DEPTH-1; i > 0; i--) sb[i] <= sb[i-1];
      sb[0] <= sb_new;
    end
  end

  // Saturating hazard-bubble counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      bubble_cnt <= '0;
    else if (stall && bubble_cnt != '1)
      bubble_cnt <= bubble_cnt + 1'b1;
  end

endmodule

// File: tb/tb_inst_issue_queue.sv
// Bench for inst_issue_queue: reset checks, a table of dependent/independent
// instruction groups, fill-to-full, empty-idle, saturation and mid-stall reset.
module tb_inst_issue_queue;
  import inst_issue_pkg::*;

  localparam int DEPTH = 4;
  localparam int HAZ   = 2;
  localparam int CW    = 2;
`ifdef INST_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [2:0]    level;
  logic [CW-1:0] bubble_cnt;

  inst_issue_queue_if bus();

  inst_issue_queue #(.DEPTH(DEPTH), .HAZ_DEPTH(HAZ), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .level      (level),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] expq[$];
  int         iss_cyc[$];
  int         cyc = 0;
  int         rdy_err = 0;
  int         lvl_err = 0;
  bit         saw_full = 1'b0;
  bit         saw_nrdy = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Issue monitor: every issued entry must match the next pushed entry
  always @(negedge clk) begin
    logic [7:0] e;
    cyc++;
    if (bus.issued === 1'b1) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL issue_unexpected got=%h want=none", bus.inst);
      end else begin
        e = expq.pop_front();
        if (bus.inst !== e) begin
          bad++;
          $display("FAIL issue_order got=%h want=%h", bus.inst, e);
        end
      end
      iss_cyc.push_back(cyc);
    end
    if (bus.in_ready !== (level < DEPTH)) rdy_err++;
    if (level > DEPTH) lvl_err++;
    if (level == DEPTH) saw_full = 1'b1;
    if (bus.in_ready === 1'b0) saw_nrdy = 1'b1;
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic push(input logic [7:0] v);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_inst  = v;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) chk("push_timeout", 0, 1);
    else expq.push_back(v);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((level != 0 || expq.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", int'(level == 0 && expq.size() == 0), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    expq.delete();
    @(negedge clk);
    iss_cyc.delete();
    rst = 1'b1;
  endtask

  typedef struct {
    logic [7:0] a, b, c;
    int         n;
    int         bub;
    int         bub_fwd;
  } vec_t;

  vec_t vt[8];

  initial begin
    int ex, b0;

    vt[0] = '{a:8'h5B, b:8'h65, c:8'h00, n:2, bub:2, bub_fwd:1}; // ADD r1 -> ADD reads r1
    vt[1] = '{a:8'h5B, b:8'h6F, c:8'h00, n:2, bub:0, bub_fwd:0}; // independent
    vt[2] = '{a:8'h90, b:8'h64, c:8'h00, n:2, bub:2, bub_fwd:1}; // SET r1 -> rs1=r1
    vt[3] = '{a:8'h5B, b:8'h90, c:8'h00, n:2, bub:0, bub_fwd:0}; // WAW only
    vt[4] = '{a:8'h00, b:8'h64, c:8'h00, n:2, bub:0, bub_fwd:0}; // NOP writes nothing
    vt[5] = '{a:8'hF0, b:8'hCB, c:8'h00, n:2, bub:2, bub_fwd:1}; // NAND r3 -> rs2=r3
    vt[6] = '{a:8'hA0, b:8'h42, c:8'h00, n:2, bub:2, bub_fwd:1}; // SET r2 -> rs2=r2
    vt[7] = '{a:8'h5B, b:8'h6F, c:8'h64, n:3, bub:1, bub_fwd:0}; // dep two back

    // Reset held with a valid offer
    bus.in_valid = 1'b1;
    bus.in_inst  = 8'h5B;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_ready", int'(bus.in_ready), 1);
      chk("rst_inst",     int'(bus.inst), 0);
      chk("rst_issued",   int'(bus.issued), 0);
      chk("rst_level",    int'(level), 0);
    end
    chk("rst_bubble_cnt", int'(bubble_cnt), 0);
    rst = 1'b1;
    expq.push_back(8'h5B);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("first_level",  int'(level), 1);
    chk("first_issued", int'(bus.issued), 0);
    @(negedge clk);
    chk("first_issue",      int'(bus.issued), 1);
    chk("first_issue_inst", int'(bus.inst), 'h5B);
    drain();

    // Empty queue: NOPs, no bubble counting
    b0 = int'(bubble_cnt);
    repeat (3) begin
      @(negedge clk);
      chk("idle_inst",   int'(bus.inst), 0);
      chk("idle_issued", int'(bus.issued), 0);
      chk("idle_bubble", int'(bubble_cnt), b0);
    end

    // Table of dependent/independent groups pushed back-to-back
    for (int i = 0; i < 8; i++) begin
      do_reset();
      push(vt[i].a);
      push(vt[i].b);
      if (vt[i].n == 3) push(vt[i].c);
      drain();
      ex = FWD ? vt[i].bub_fwd : vt[i].bub;
      chk($sformatf("vec%0d_bubble_cnt", i), int'(bubble_cnt), ex);
      chk($sformatf("vec%0d_issues", i), iss_cyc.size(), vt[i].n);
      if (iss_cyc.size() == vt[i].n)
        chk($sformatf("vec%0d_gap", i), iss_cyc[vt[i].n-1] - iss_cyc[0], vt[i].n - 1 + ex);
    end

    // Fill to full behind a dependent chain, then independent SETs
    do_reset();
    saw_full = 1'b0;
    saw_nrdy = 1'b0;
    rdy_err  = 0;
    lvl_err  = 0;
    push(8'h90);
    repeat (6) push(8'h55);
    push(8'hA0); push(8'hB0); push(8'h80); push(8'h90); push(8'hA0);
    drain();
    chk("fill_saw_full",  int'(saw_full), 1);
    chk("fill_saw_nrdy",  int'(saw_nrdy), 1);
    chk("fill_ready_err", rdy_err, 0);
    chk("fill_level_err", lvl_err, 0);
    chk("fill_issues",    iss_cyc.size(), 12);

    // Saturation of the 2-bit bubble counter
    do_reset();
    push(8'h90);
    repeat (5) push(8'h55);
    drain();
    chk("sat_bubble_cnt", int'(bubble_cnt), 3);

    // Asynchronous reset with three entries queued and the head stalled
    do_reset();
    push(8'h90);
    repeat (FWD ? 4 : 3) push(8'h55);
    chk("mid_level",  int'(level), 3);
    chk("mid_stall",  int'(bus.issued), 0);
    rst = 1'b0;
    #1;
    chk("async_inst",   int'(bus.inst), 0);
    chk("async_issued", int'(bus.issued), 0);
    chk("async_level",  int'(level), 0);
    chk("async_bubble", int'(bubble_cnt), 0);
    expq.delete();
    @(negedge clk);
    iss_cyc.delete();
    rst = 1'b1;
    push(8'h6F);
    drain();
    chk("post_rst_issues", iss_cyc.size(), 1);
    chk("post_rst_bubble", int'(bubble_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
